// File: rtl/rv32_lsu_pkg.sv
// Shared types and constants for the RV32 MEM-stage load/store unit:
// FSM states, funct3 encodings, fault causes and fault-check helpers.
package rv32_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_MISALIGNED = 2'b00,
    CAUSE_ILLEGAL    = 2'b01,
    CAUSE_BUS_ERR    = 2'b10,
    CAUSE_TIMEOUT    = 2'b11
  } lsu_cause_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size is funct3[1:0] for every legal load and store.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 > F3_SW;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane steering: store byte-enables/replicated data,
// and load byte/halfword extraction with sign or zero extension.
module lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword loads are aligned, so shifting by the byte offset lands either lane at bit 0.
  assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LBU:  ld_data = {24'b0, ld_shifted[7:0]};
      F3_LHU:  ld_data = {16'b0, ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: checks the access, runs one req/gnt/rvalid
// data-bus transaction, stalls the pipeline meanwhile and reports faults.
module mem_stage_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic [2:0]            M_Funct3,
  input  logic [ADDR_WIDTH-1:0] M_ALUResult,
  input  logic [DATA_WIDTH-1:0] M_WriteData,
  output logic [DATA_WIDTH-1:0] M_ReadData,
  output logic                  M_LoadValid,
  output logic                  lsu_stall,
  output logic                  lsu_fault,
  output logic [1:0]            lsu_fault_cause,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [3:0]            dbus_be,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  input  logic                  dbus_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  load_valid_q;
  logic                  fault_q;
  lsu_cause_e            cause_q;

  logic       op_valid, is_store, illegal, misaligned;
  logic       idle_fault, issue, resp_accept, timeout_hit;
  lsu_cause_e idle_cause;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata, ld_data;

  // Both MemRead and MemWrite high is a store.
  assign op_valid   = M_MemRead | M_MemWrite;
  assign is_store   = M_MemWrite;
  assign illegal    = funct3_illegal(is_store, M_Funct3);
  assign misaligned = addr_misaligned(M_Funct3[1:0], M_ALUResult[1:0]);
  assign idle_fault = (state == S_IDLE) && op_valid && (illegal || misaligned);
  assign issue      = (state == S_IDLE) && op_valid && !illegal && !misaligned;
  assign idle_cause = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;

  assign resp_accept = dbus_rvalid && (((state == S_REQ) && dbus_gnt) || (state == S_RESP));
  assign timeout_hit = (cnt == CNT_LAST) &&
                       (((state == S_REQ) && !dbus_gnt) || ((state == S_RESP) && !dbus_rvalid));

  lsu_align u_align (
    .st_size    (M_Funct3[1:0]),
    .st_addr_lo (M_ALUResult[1:0]),
    .st_data    (M_WriteData),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (dbus_rdata),
    .ld_data    (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt          <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_MISALIGNED;
    end else begin
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state)
        S_IDLE: if (issue) begin
          addr_q   <= M_ALUResult;
          funct3_q <= M_Funct3;
          we_q     <= is_store;
          be_q     <= is_store ? st_be : 4'b1111;
          wdata_q  <= st_wdata;
          cnt      <= '0;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (resp_accept || timeout_hit) begin
            state <= S_DONE;
          end else if (dbus_gnt) begin
            cnt   <= '0;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_accept || timeout_hit) state <= S_DONE;
          else                            cnt   <= cnt + CNT_W'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Bus and timeout faults surface in DONE, the cycle the pipeline advances.
      if (resp_accept) begin
        if (dbus_err) begin
          fault_q <= 1'b1;
          cause_q <= CAUSE_BUS_ERR;
        end else if (!we_q) begin
          rdata_q      <= ld_data;
          load_valid_q <= 1'b1;
        end
      end
      if (timeout_hit) begin
        fault_q <= 1'b1;
        cause_q <= CAUSE_TIMEOUT;
      end
    end
  end

  // The detect cycle stalls combinationally so the op is held until the bus completes.
  assign lsu_stall       = issue || (state == S_REQ) || (state == S_RESP);
  assign lsu_fault       = idle_fault || fault_q;
  assign lsu_fault_cause = idle_fault ? idle_cause : (fault_q ? cause_q : 2'b00);
  assign M_ReadData      = rdata_q;
  assign M_LoadValid     = load_valid_q;
  assign dbus_req        = (state == S_REQ);
  assign dbus_we         = we_q;
  assign dbus_be         = be_q;
  assign dbus_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dbus_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: a reactive bus model
// plus hand-computed expectations for lanes, extension, faults and timing.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, to_read;
  logic [2:0]  funct3;
  logic [31:0] alu_result, write_data, rdata;
  logic        gnt, rvalid, err;
  logic        to_gnt;

  logic [31:0] read_data, dbus_addr, dbus_wdata;
  logic        load_valid, lsu_stall, lsu_fault, dbus_req, dbus_we;
  logic [1:0]  fault_cause;
  logic [3:0]  dbus_be;

  logic [31:0] to_read_data, to_addr, to_wdata;
  logic        to_load_valid, to_stall, to_fault, to_req, to_we;
  logic [1:0]  to_cause;
  logic [3:0]  to_be;

  int tests_run = 0;
  int tests_failed = 0;

  int          s_stalls, s_reqs, s_faults, s_lvs;
  logic [1:0]  s_cause;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;
  logic        s_we, s_stable;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .M_MemRead(mem_read), .M_MemWrite(mem_write), .M_Funct3(funct3),
    .M_ALUResult(alu_result), .M_WriteData(write_data),
    .M_ReadData(read_data), .M_LoadValid(load_valid),
    .lsu_stall(lsu_stall), .lsu_fault(lsu_fault), .lsu_fault_cause(fault_cause),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_gnt(gnt), .dbus_rvalid(rvalid), .dbus_rdata(rdata), .dbus_err(err)
  );

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .M_MemRead(to_read), .M_MemWrite(1'b0), .M_Funct3(funct3),
    .M_ALUResult(alu_result), .M_WriteData(write_data),
    .M_ReadData(to_read_data), .M_LoadValid(to_load_valid),
    .lsu_stall(to_stall), .lsu_fault(to_fault), .lsu_fault_cause(to_cause),
    .dbus_req(to_req), .dbus_we(to_we), .dbus_be(to_be),
    .dbus_addr(to_addr), .dbus_wdata(to_wdata),
    .dbus_gnt(to_gnt), .dbus_rvalid(rvalid), .dbus_rdata(rdata), .dbus_err(err)
  );

  // One access on dut: op shown for one cycle, gnt after gnt_wait withheld
  // request cycles, response the cycle after gnt (or with it if same_cycle).
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rsp, input logic rsp_err,
                           input int gnt_wait, input logic same_cycle);
    int   waited = 0;
    logic pend   = 1'b0;
    bit   done   = 1'b0;
    s_stalls = 0; s_reqs = 0; s_faults = 0; s_lvs = 0; s_cause = 2'b00;
    s_be = '0; s_addr = '0; s_wdata = '0; s_we = 1'b0; s_stable = 1'b1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      mem_read   = (cyc == 0) ? rd : 1'b0;
      mem_write  = (cyc == 0) ? wr : 1'b0;
      funct3     = f3;
      alu_result = a;
      write_data = wd;
      rdata      = rsp;
      err        = rsp_err;
      rvalid     = pend;
      pend       = 1'b0;
      gnt        = 1'b0;
      if (dbus_req) begin
        if (waited >= gnt_wait) begin
          gnt = 1'b1;
          if (same_cycle) rvalid = 1'b1;
          else            pend   = 1'b1;
        end else begin
          waited++;
        end
      end
      #1;
      if (lsu_stall) s_stalls++;
      if (dbus_req) begin
        if (s_reqs == 0) begin
          s_be = dbus_be; s_addr = dbus_addr; s_wdata = dbus_wdata; s_we = dbus_we;
        end else if (dbus_be !== s_be || dbus_addr !== s_addr ||
                     dbus_wdata !== s_wdata || dbus_we !== s_we) begin
          s_stable = 1'b0;
        end
        s_reqs++;
      end
      if (lsu_fault) begin
        s_faults++;
        s_cause = fault_cause;
      end
      if (load_valid) s_lvs++;
      if (!lsu_stall) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      $display("FAIL access_complete: stall still high after 300 cycles, expected release");
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; to_read = 1'b0; to_gnt = 1'b0;
    funct3 = '0; alu_result = '0; write_data = '0; rdata = '0;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    #12;
    tests_run++;
    if ({dbus_req, dbus_we, lsu_stall, lsu_fault, load_valid} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000",
               {dbus_req, dbus_we, lsu_stall, lsu_fault, load_valid});
      tests_failed++;
    end
    tests_run++;
    if ({dbus_be, fault_cause} !== 6'b0) begin
      $display("FAIL reset_be_cause: got %h expected 00", {dbus_be, fault_cause});
      tests_failed++;
    end
    tests_run++;
    if ({dbus_addr, dbus_wdata, read_data} !== 96'b0) begin
      $display("FAIL reset_data: got %h %h %h expected zeros", dbus_addr, dbus_wdata, read_data);
      tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_noop();
    do_access(1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_stalls !== 0 || s_reqs !== 0) begin
      $display("FAIL noop: got stalls=%0d reqs=%0d expected 0 0", s_stalls, s_reqs);
      tests_failed++;
    end
  endtask

  task automatic test_store_word();
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_stalls !== 3) begin
      $display("FAIL sw_stalls: got %0d expected 3", s_stalls); tests_failed++;
    end
    tests_run++;
    if (s_reqs !== 1 || s_faults !== 0 || s_lvs !== 0) begin
      $display("FAIL sw_counts: got reqs=%0d faults=%0d lvs=%0d expected 1 0 0",
               s_reqs, s_faults, s_lvs);
      tests_failed++;
    end
    tests_run++;
    if ({s_we, s_be, s_addr, s_wdata} !== {1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF}) begin
      $display("FAIL sw_bus: got we=%b be=%h addr=%h wdata=%h expected 1 f 00001000 deadbeef",
               s_we, s_be, s_addr, s_wdata);
      tests_failed++;
    end
  endtask

  task automatic test_load_byte();
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 1'b0);
    tests_run++;
    if (read_data !== 32'hFFFF_FF80 || s_lvs !== 1) begin
      $display("FAIL lb: got %h lvs=%0d expected ffffff80 1", read_data, s_lvs);
      tests_failed++;
    end
    tests_run++;
    if (s_stalls !== 3 || s_be !== 4'hF || s_addr !== 32'h0000_2000) begin
      $display("FAIL lb_bus: got stalls=%0d be=%h addr=%h expected 3 f 00002000",
               s_stalls, s_be, s_addr);
      tests_failed++;
    end
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 1'b0);
    tests_run++;
    if (read_data !== 32'h0000_0080 || s_lvs !== 1) begin
      $display("FAIL lbu: got %h lvs=%0d expected 00000080 1", read_data, s_lvs);
      tests_failed++;
    end
  endtask

  task automatic test_halfword_and_lanes();
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_be !== 4'b1100 || s_wdata !== 32'h1234_1234) begin
      $display("FAIL sh: got be=%b wdata=%h expected 1100 12341234", s_be, s_wdata);
      tests_failed++;
    end
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hABCD_0000, 1'b0, 0, 1'b0);
    tests_run++;
    if (read_data !== 32'h0000_ABCD) begin
      $display("FAIL lhu: got %h expected 0000abcd", read_data); tests_failed++;
    end
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hABCD_0000, 1'b0, 0, 1'b0);
    tests_run++;
    if (read_data !== 32'hFFFF_ABCD) begin
      $display("FAIL lh: got %h expected ffffabcd", read_data); tests_failed++;
    end
    do_access(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_be !== 4'b0010 || s_wdata !== 32'hA5A5_A5A5 || s_addr !== 32'h0000_1000) begin
      $display("FAIL sb: got be=%b wdata=%h addr=%h expected 0010 a5a5a5a5 00001000",
               s_be, s_wdata, s_addr);
      tests_failed++;
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h1234_5678, 1'b0, 0, 1'b0);
    tests_run++;
    if (read_data !== 32'h1234_5678 || s_be !== 4'hF || s_we !== 1'b0) begin
      $display("FAIL lw: got %h be=%h we=%b expected 12345678 f 0", read_data, s_be, s_we);
      tests_failed++;
    end
  endtask

  task automatic test_faults();
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_faults !== 1 || s_cause !== 2'b00 || s_reqs !== 0 || s_stalls !== 0) begin
      $display("FAIL lw_misaligned: got faults=%0d cause=%b reqs=%0d stalls=%0d expected 1 00 0 0",
               s_faults, s_cause, s_reqs, s_stalls);
      tests_failed++;
    end
    do_access(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_faults !== 1 || s_cause !== 2'b01 || s_reqs !== 0) begin
      $display("FAIL load_illegal: got faults=%0d cause=%b reqs=%0d expected 1 01 0",
               s_faults, s_cause, s_reqs);
      tests_failed++;
    end
    do_access(1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_faults !== 1 || s_cause !== 2'b01) begin
      $display("FAIL store_illegal: got faults=%0d cause=%b expected 1 01", s_faults, s_cause);
      tests_failed++;
    end
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_faults !== 1 || s_cause !== 2'b00 || read_data !== 32'h1234_5678) begin
      $display("FAIL sh_misaligned: got faults=%0d cause=%b rd=%h expected 1 00 12345678",
               s_faults, s_cause, read_data);
      tests_failed++;
    end
    do_access(1'b1, 1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_we !== 1'b1 || s_wdata !== 32'hCAFE_F00D || s_lvs !== 0 || s_faults !== 0) begin
      $display("FAIL rd_wr_both: got we=%b wdata=%h lvs=%0d faults=%0d expected 1 cafef00d 0 0",
               s_we, s_wdata, s_lvs, s_faults);
      tests_failed++;
    end
  endtask

  task automatic test_wait_bus_error();
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h5555_5555, 1'b1, 5, 1'b0);
    tests_run++;
    if (s_reqs !== 6 || s_stable !== 1'b1 || s_stalls !== 8) begin
      $display("FAIL wait_req: got reqs=%0d stable=%b stalls=%0d expected 6 1 8",
               s_reqs, s_stable, s_stalls);
      tests_failed++;
    end
    tests_run++;
    if (s_faults !== 1 || s_cause !== 2'b10 || s_lvs !== 0 || read_data !== 32'h1234_5678) begin
      $display("FAIL bus_err: got faults=%0d cause=%b lvs=%0d rd=%h expected 1 10 0 12345678",
               s_faults, s_cause, s_lvs, read_data);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back_same_cycle();
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4008, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 1'b1);
    tests_run++;
    if (s_stalls !== 2 || s_lvs !== 1 || read_data !== 32'h0BAD_CAFE) begin
      $display("FAIL gnt_rvalid_same: got stalls=%0d lvs=%0d rd=%h expected 2 1 0badcafe",
               s_stalls, s_lvs, read_data);
      tests_failed++;
    end
  endtask

  task automatic test_timeout();
    int   reqs = 0;
    bit   seen = 1'b0;
    logic [1:0] cause = 2'b00;
    logic stall_at_fault = 1'b1;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    to_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_5000;
    #1;
    tests_run++;
    if (to_stall !== 1'b1) begin
      $display("FAIL timeout_detect: got stall=%b expected 1", to_stall); tests_failed++;
    end
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      to_read = 1'b0;
      #1;
      if (to_req) reqs++;
      if (to_fault) begin
        seen = 1'b1;
        cause = to_cause;
        stall_at_fault = to_stall;
      end
    end
    tests_run++;
    if (!seen || reqs !== 4 || cause !== 2'b11 || stall_at_fault !== 1'b0) begin
      $display("FAIL timeout: got seen=%b reqs=%0d cause=%b stall=%b expected 1 4 11 0",
               seen, reqs, cause, stall_at_fault);
      tests_failed++;
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({to_req, to_stall, to_fault} !== 3'b000) begin
      $display("FAIL timeout_idle: got %b expected 000", {to_req, to_stall, to_fault});
      tests_failed++;
    end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h0000_6000;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    gnt = 1'b1;
    #1;
    tests_run++;
    if (dbus_req !== 1'b1) begin
      $display("FAIL rst_pre_req: got %b expected 1", dbus_req); tests_failed++;
    end
    @(negedge clk);
    gnt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dbus_req, dbus_we, lsu_stall, lsu_fault, load_valid, dbus_be, fault_cause} !== 11'b0 ||
        {dbus_addr, dbus_wdata, read_data} !== 96'b0) begin
      $display("FAIL rst_in_resp: got flags=%b addr=%h wdata=%h rd=%h expected all zero",
               {dbus_req, dbus_we, lsu_stall, lsu_fault, load_valid, dbus_be, fault_cause},
               dbus_addr, dbus_wdata, read_data);
      tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({dbus_req, lsu_stall} !== 2'b00) begin
      $display("FAIL rst_idle: got %b expected 00", {dbus_req, lsu_stall}); tests_failed++;
    end
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_7000, 32'h0102_0304, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (s_stalls !== 3 || s_reqs !== 1 || s_addr !== 32'h0000_7000) begin
      $display("FAIL rst_recover: got stalls=%0d reqs=%0d addr=%h expected 3 1 00007000",
               s_stalls, s_reqs, s_addr);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_noop();
    test_store_word();
    test_load_byte();
    test_halfword_and_lanes();
    test_faults();
    test_wait_bus_error();
    test_back_to_back_same_cycle();
    test_timeout();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the RV32 5-stage pipeline. It consumes the EX/MEM register outputs (address, store data, control) and runs the data-bus transaction using a req/gnt/rvalid handshake. It stalls the pipeline until the access completes, returns load data sign- or zero-extended for the MEM/WB register, and flags misaligned, illegal, bus-error and timeout faults.

Parameters:
DATA_WIDTH, 32, data path width; fixed at 32, no other value supported
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, maximum cycles waiting for gnt or rvalid before timeout fault; must be >= 1

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
M_MemRead  input  1  load in MEM stage
M_MemWrite  input  1  store in MEM stage
M_Funct3  input  3  RV32 load/store funct3
M_ALUResult  input  ADDR_WIDTH  effective byte address
M_WriteData  input  DATA_WIDTH  store data (rs2)
M_ReadData  output  DATA_WIDTH  formatted load result, registered
M_LoadValid  output  1  one-cycle pulse: M_ReadData updated
lsu_stall  output  1  freeze IF..MEM and bubble WB while high
lsu_fault  output  1  one-cycle pulse: access aborted
lsu_fault_cause  output  2  00 misaligned, 01 illegal funct3, 10 bus error, 11 timeout
dbus_req  output  1  request valid
dbus_we  output  1  1 = write
dbus_be  output  4  byte enables
dbus_addr  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
dbus_wdata  output  DATA_WIDTH  lane-aligned store data
dbus_gnt  input  1  request accepted
dbus_rvalid  input  1  response valid (read data or write ack)
dbus_rdata  input  DATA_WIDTH  read data
dbus_err  input  1  qualified by dbus_rvalid

Behaviour:
- Reset: state IDLE, every output 0, timeout counter 0, captured addr/funct3/we cleared. A reset mid-transaction abandons the access; no response is expected afterwards.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no op (MemRead=MemWrite=0): lsu_stall=0 and dbus_req=0.
- IDLE, op present: check for faults first.
  - Illegal funct3: load with 011/110/111, or store with funct3 > 010.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On a fault: lsu_fault pulses the same cycle, lsu_stall=0, no bus request, stay in IDLE.
  - Otherwise: latch addr/funct3/we/wdata, lsu_stall=1 combinationally, go to REQ.
- MemRead and MemWrite both high: treated as a store.
- REQ:
  - dbus_req=1, bus outputs driven from the latched values.
  - On gnt, go to RESP and clear the counter.
  - Otherwise increment the counter; when it reaches TIMEOUT_CYCLES, raise fault 11 and go to DONE.
  - req stays asserted with stable address/data until gnt.
- RESP:
  - dbus_req=0.
  - On rvalid with err=1: fault 10, go to DONE.
  - On rvalid with err=0: for loads, register the formatted data into M_ReadData and pulse M_LoadValid; go to DONE.
  - Same timeout rule as REQ.
- gnt and rvalid in the same cycle while in REQ: the response is accepted directly (REQ->DONE). RESP is skipped.
- DONE: lsu_stall=0 for exactly one cycle so the pipeline advances, then IDLE. No new request is sampled in DONE, so the same instruction is never issued twice.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], byte replicated x4.
  - SH: be = addr[1] ? 1100 : 0011, halfword replicated x2.
  - SW: be = 1111, wdata unchanged.
- Loads: dbus_be=1111. The byte or halfword is selected by addr[1:0].
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: passed through.
- M_ReadData holds its value until the next successful load.
- Worst-case latency with zero-wait bus (gnt in the req cycle, rvalid the next cycle): 3 stalled cycles total (IDLE detect, REQ, RESP), then DONE.

Decomposition:
- Shared package rv32_lsu_pkg holds:
  - state encoding
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010)
  - fault cause codes
- One sub-module, lsu_align: purely combinational byte-enable/wdata steering and load extraction/extension. The FSM and counter stay in mem_stage_lsu.

Test Plan:
- SW addr=0x1000, wdata=0xDEADBEEF, gnt same cycle, rvalid next -> dbus_be=1111, dbus_addr=0x1000, lsu_stall high 3 cycles, no fault.
- LB addr=0x2003, rdata=0x80FF_FFFF -> M_ReadData=0xFFFFFF80; same with LBU -> 0x00000080; M_LoadValid one pulse each.
- SH addr=0x2002, wdata=0x0000_1234 -> be=1100, dbus_wdata=0x12341234; LHU addr=0x2002, rdata=0xABCD0000 -> 0x0000ABCD.
- LW addr=0x3001 -> lsu_fault=1, cause=00, no dbus_req, lsu_stall=0; funct3=011 load -> cause=01.
- gnt withheld 5 cycles then granted, rvalid with err=1 -> req held stable 6 cycles, fault cause=10, M_ReadData unchanged.
- TIMEOUT_CYCLES=4, gnt never asserted -> fault cause=11 after 4 REQ cycles, DONE, IDLE; separately, rst_n pulsed in RESP -> all outputs 0, state IDLE.
